key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 148 ++++++++++++++
 rtl/key_conditioner.sv | 35 +++
 tb/tb_key_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and defaults for the four-key pushbutton conditioner.
// Default timing constants assume the 50 MHz CLOCK_50 domain.
package key_pkg;

    localparam int unsigned NUM_KEYS            = 4;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
    localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
    localparam int unsigned DEF_REPEAT_PERIOD   = 10000000;  // 200 ms

    typedef enum logic [1:0] {
        StReleased,
        StPressPend,
        StPressed,
        StReleasePend
    } key_state_e;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce FSM with stability counter and,
// when KEY_REPEAT_EN is defined, an auto-repeat counter active while the key is held.
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // The sample that opened the PEND state and the current sample both count as stable,
    // so acceptance comes when the counter is two short of DEBOUNCE_CYCLES.
    localparam int unsigned ACCEPT_AT = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES - 2 : 0;

    if (DEBOUNCE_CYCLES == 0 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_param
        $error("key_debounce_ch: timing parameters must be non-zero");
    end

    logic             sync_q1, sync_q2;
    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             pressed_smp, accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            state_q   <= StReleased;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q1   <= key_n;
            sync_q2   <= sync_q1;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign pressed_smp = ~sync_q2;
    assign accept      = (cnt_q >= CNT_W'(ACCEPT_AT));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            StReleased: begin
                if (pressed_smp) begin
                    state_d = StPressPend;
                    cnt_d   = '0;
                end
            end
            StPressPend: begin
                if (!pressed_smp) begin
                    state_d = StReleased;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StPressed: begin
                if (!pressed_smp) begin
                    state_d = StReleasePend;
                    cnt_d   = '0;
                end
            end
            StReleasePend: begin
                if (pressed_smp) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (accept) begin
                    state_d   = StReleased;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StReleased;
                cnt_d   = '0;
            end
        endcase
    end

    assign level         = (state_q == StPressed) || (state_q == StReleasePend);
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef KEY_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_q, rep_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
        end
    end

    // Down-counter: loaded with the initial delay on entry to PRESSED, then the period.
    always_comb begin
        rep_d     = 1'b0;
        rep_cnt_d = '0;
        if (state_d == StPressed && state_q != StPressed) begin
            rep_cnt_d = REP_W'(REPEAT_DELAY - 1);
        end else if (state_d == StPressed && state_q == StPressed) begin
            if (rep_cnt_q == '0) begin
                rep_d     = 1'b1;
                rep_cnt_d = REP_W'(REPEAT_PERIOD - 1);
            end else begin
                rep_cnt_d = rep_cnt_q - REP_W'(1);
            end
        end
    end

    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions the four active-low pushbuttons into debounced levels and press/release pulses;
// auto-repeat pulses are built only when KEY_REPEAT_EN is defined.
module key_conditioner
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_repeat
);

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .key_n        (key_n[k]),
            .level        (key_level[k]),
            .press_pulse  (key_press[k]),
            .release_pulse(key_release[k]),
            .repeat_pulse (key_repeat[k])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3;
// repeat expectations follow whether KEY_REPEAT_EN is defined for the build.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_n;
    logic [3:0] key_level, key_press, key_release, key_repeat;

    int n_checks = 0;
    int n_fail   = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_repeat (key_repeat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] kn;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rls;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] kn, input logic [3:0] lvl,
                                input logic [3:0] prs, input logic [3:0] rls, input int n);
        vec_t v;
        v.kn  = kn;
        v.lvl = lvl;
        v.prs = prs;
        v.rls = rls;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check({name, ".level"}, key_level, 4'b0000);
        check({name, ".press"}, key_press, 4'b0000);
        check({name, ".release"}, key_release, 4'b0000);
        check({name, ".repeat"}, key_repeat, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_rep;
        bit         rep_en;
`ifdef KEY_REPEAT_EN
        rep_en = 1'b1;
`else
        rep_en = 1'b0;
`endif
        // Cycle-by-cycle vectors: raw key_n applied, expected outputs after the next edge.
        add(4'b1110, 4'b0000, 4'b0000, 4'b0000, 5);   // clean press key0
        add(4'b1110, 4'b0001, 4'b0001, 4'b0000, 1);
        add(4'b1110, 4'b0001, 4'b0000, 4'b0000, 1);
        add(4'b1111, 4'b0001, 4'b0000, 4'b0000, 5);   // release key0
        add(4'b1111, 4'b0000, 4'b0000, 4'b0001, 1);
        add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);
        add(4'b1101, 4'b0000, 4'b0000, 4'b0000, 3);   // 3-cycle glitch on key1
        add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 7);
        add(4'b0110, 4'b0000, 4'b0000, 4'b0000, 5);   // key0 + key3 together
        add(4'b0110, 4'b1001, 4'b1001, 4'b0000, 1);
        add(4'b0110, 4'b1001, 4'b0000, 4'b0000, 1);
        add(4'b1111, 4'b1001, 4'b0000, 4'b0000, 5);
        add(4'b1111, 4'b0000, 4'b0000, 4'b1001, 1);
        add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 2);

        rst   = 1'b1;
        key_n = 4'b1111;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();

        foreach (vecs[i]) begin
            key_n = vecs[i].kn;
            tick();
            check($sformatf("vec%0d.level", i), key_level, vecs[i].lvl);
            check($sformatf("vec%0d.press", i), key_press, vecs[i].prs);
            check($sformatf("vec%0d.release", i), key_release, vecs[i].rls);
            check($sformatf("vec%0d.repeat", i), key_repeat, 4'b0000);
        end

        // Key2 held through reset is taken as a fresh press after reset falls.
        rst   = 1'b1;
        key_n = 4'b1011;
        tick();
        tick();
        check_all_zero("hold_rst");
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick();
            check($sformatf("hold_rst.press%0d", i), key_press, (i == 6) ? 4'b0100 : 4'b0000);
        end
        key_n = 4'b1111;
        for (int i = 0; i < 8; i++) tick();

        // Key3 pressed, then reset lands just before key1's press would be accepted.
        key_n = 4'b0111;
        for (int i = 0; i < 7; i++) tick();
        check("pre_abort.level", key_level, 4'b1000);
        key_n = 4'b0101;
        for (int i = 0; i < 5; i++) tick();
        check("pre_abort.level2", key_level, 4'b1000);
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        key_n = 4'b1111;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("abort.press%0d", i), key_press, 4'b0000);
            check($sformatf("abort.release%0d", i), key_release, 4'b0000);
        end

        // Auto-repeat on key0: rel counts cycles from the press pulse.
        key_n = 4'b1110;
        for (int i = 0; i < 20 && key_press[0] !== 1'b1; i++) tick();
        check("rep.press", key_press, 4'b0001);
        for (int rel = 0; rel <= 35; rel++) begin
            if (rel > 0) tick();
            exp_rep = (rep_en && rel >= 10 && rel <= 22 && (rel - 10) % 3 == 0) ? 4'b0001
                                                                                : 4'b0000;
            check($sformatf("rep.rel%0d", rel), key_repeat, exp_rep);
            if (rel == 22) key_n = 4'b1111;
        end
        check("rep.level_after", key_level, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
